window_3x3: RTL and testbench
=============================

# window_3x3

Streaming 3×3 neighbourhood generator sitting directly downstream of `rom_control` and its image ROM. It consumes one pixel per valid cycle, tagged with the `row`/`column` coordinates `rom_control` issues, plus the ROM read data. It keeps the two previous image lines and emits a packed 3×3 window, with centre coordinates, to the filter stages that follow.

## Interface
Parameters:
- `IMG_W`, 160, pixels per line (≤256)
- `IMG_H`, 120, lines per frame (≤256)
- `DATA_W`, 8, pixel width

Ports:
- `clk` in 1: system clock, rising edge
- `rstn` in 1: reset, asynchronous, active-low
- `pix_valid` in 1: pixel qualifier; `rom_rd_en` delayed by the ROM read latency
- `pix_data` in DATA_W: ROM read data
- `column` in 8: column of `pix_data`, aligned with `pix_valid`
- `row` in 8: row of `pix_data`, aligned with `pix_valid`
- `win_valid` out 1: window qualifier, single-cycle per window
- `win_data` out 9*DATA_W: window; element k=3*r+c at `[k*DATA_W +: DATA_W]`; r=0 top (row-2), c=0 left (column-2); k=8 is the input pixel
- `win_row` out 8: centre row (input row-1)
- `win_col` out 8: centre column (input column-1)
- `frame_done` out 1: only with `WIN_FRAME_DONE_EN`

## Operation
- Accepted pixel: `pix_valid`=1 and `column`<IMG_W and `row`<IMG_H. Any other combination is ignored and no state changes.
- Line storage: two IMG_W-deep line memories, LB1 holds the previous line and LB2 the line before it, both indexed by `column`.
- On an accepted pixel:
  - Read LB1[col] and LB2[col].
  - Write LB2[col]←LB1[col] and LB1[col]←`pix_data`.
  - Shift the 3-column register window left by one, loading the new column {LB2,LB1,pix} into c=2.
- Arm flag:
  - Cleared by reset.
  - Set by an accepted pixel at (0,0).
  - While clear, no window is emitted.
- A window is emitted for an accepted pixel when armed=1, `row`≥2 and `column`≥2. This yields (IMG_W-2)×(IMG_H-2) windows per frame. Border pixels are never centres.
- Window columns left over from the previous line are masked by the `column`≥2 rule; no explicit flush is needed.
- `pix_valid` gaps of any length are allowed. The window register holds its contents across gaps. The pipeline is fixed-latency and never back-pressures upstream.
- A new (0,0) during a frame restarts cleanly. Line contents from the prior frame are masked by the `row`≥2 rule.
- Line memories are not reset; their contents are don't-care until overwritten.

## Timing
- Latency is 2 cycles.
  - Pixel accepted at edge N: the line-memory read is registered at N.
  - Window, `win_valid`, `win_row` and `win_col` are registered at N+1.
  - All are valid in the cycle after edge N+1.
- Back-to-back accepted pixels give back-to-back windows, one per cycle.
- Reset values: `win_valid`=0, `win_data`=0, `win_row`=0, `win_col`=0, `frame_done`=0, armed=0, all pipeline valids=0.
- Reset asserted mid-frame:
  - Outputs clear immediately (asynchronously).
  - In-flight windows are dropped.
  - Output stays silent until the next (0,0) is accepted.
- Read-before-write on the same address in the same cycle: the read returns the old data.

## Configuration
- `WIN_FRAME_DONE_EN` defined:
  - Adds output port `frame_done` (1 bit, reset 0).
  - It pulses high for one cycle, coincident with `win_valid`, for the window whose input pixel is (IMG_H-1, IMG_W-1).
- `WIN_FRAME_DONE_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `img_pkg`:
  - `DATA_W`, `IMG_W`, `IMG_H` defaults
  - `COORD_W`=8
  - window element index constants `WIN_P00`…`WIN_P22`
- One sub-module, `line_ram`: single-port-read/single-port-write synchronous RAM, IMG_W×DATA_W, registered read. It is instantiated twice (LB1, LB2). All control lives in `window_3x3`.

## Test plan
Common bench setup: IMG_W=8, IMG_H=6, pix_data = row*16+column, pix_valid held high.
- Streaming one frame:
  - Exactly 24 windows.
  - First window: win_row=1, win_col=1, elements k0..k8 = 0x00,01,02,10,11,12,20,21,22.
  - That first window appears 2 cycles after input (2,2).
- Last window:
  - win_row=4, win_col=6, k8=0x57, k0=0x35.
  - With `WIN_FRAME_DONE_EN`, `frame_done`=1 in the same cycle only.
- Random gaps (pix_valid ~50% duty):
  - Same 24 windows with identical data.
  - Each window appears 2 cycles after its pixel.
- Reset and restart:
  - Reset asserted during row 3: all outputs 0 immediately.
  - Resume at (3,0) without passing (0,0): no windows.
  - Next frame from (0,0): the full 24 windows.
- Invalid inputs:
  - pix_valid=1 with column=8, or with row=6: no state change.
  - The subsequent window equals that of an uninterrupted run.
- Back-to-back frames: the second frame's first window k0..k8 = 0x00…0x22, with no data from frame 1.

Source files
------------

// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared image geometry defaults and 3x3 window element indices
package img_pkg;

  localparam int DATA_W  = 8;
  localparam int IMG_W   = 160;
  localparam int IMG_H   = 120;
  localparam int COORD_W = 8;

  // Window element k = 3*r + c; r=0 is the oldest line, c=0 the oldest column.
  localparam int WIN_P00 = 0;
  localparam int WIN_P01 = 1;
  localparam int WIN_P02 = 2;
  localparam int WIN_P10 = 3;
  localparam int WIN_P11 = 4;
  localparam int WIN_P12 = 5;
  localparam int WIN_P20 = 6;
  localparam int WIN_P21 = 7;
  localparam int WIN_P22 = 8;

  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - one-line pixel store, synchronous write, registered read-before-write
module line_ram #(
  parameter int DEPTH = 160,
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately unreset; the caller masks stale lines.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/window_3x3.sv
// rtl/window_3x3.sv - streaming 3x3 neighbourhood generator; optional frame_done under WIN_FRAME_DONE_EN
module window_3x3 #(
  parameter int IMG_W  = img_pkg::IMG_W,
  parameter int IMG_H  = img_pkg::IMG_H,
  parameter int DATA_W = img_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        pix_valid,
  input  logic [DATA_W-1:0]           pix_data,
  input  logic [img_pkg::COORD_W-1:0] column,
  input  logic [img_pkg::COORD_W-1:0] row,
  output logic                        win_valid,
  output logic [9*DATA_W-1:0]         win_data,
  output logic [img_pkg::COORD_W-1:0] win_row,
  output logic [img_pkg::COORD_W-1:0] win_col
`ifdef WIN_FRAME_DONE_EN
  ,
  output logic                        frame_done
`endif
);

  import img_pkg::*;

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COORD_W:0]   W_LIM  = (COORD_W+1)'(IMG_W);
  localparam logic [COORD_W:0]   H_LIM  = (COORD_W+1)'(IMG_H);
  localparam logic [COORD_W-1:0] LAST_R = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] LAST_C = COORD_W'(IMG_W - 1);

  logic              accept;
  logic              emit;
  logic [AW-1:0]     addr;
  logic              armed;

  logic              s1_valid;
  logic              s1_emit;
  logic [DATA_W-1:0] s1_pix;
  logic [COORD_W-1:0] s1_row;
  logic [COORD_W-1:0] s1_col;
  logic [AW-1:0]     s1_addr;

  logic [DATA_W-1:0] lb1_q;
  logic [DATA_W-1:0] lb2_q;
  logic [DATA_W-1:0] win [9];

  assign accept = pix_valid && ({1'b0, column} < W_LIM) && ({1'b0, row} < H_LIM);
  assign emit   = accept && armed && (row >= COORD_W'(2)) && (column >= COORD_W'(2));
  assign addr   = column[AW-1:0];

  line_ram #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(AW)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .waddr (addr),
    .wdata (pix_data),
    .re    (accept),
    .raddr (addr),
    .rdata (lb1_q)
  );

  // LB2 takes LB1's old value one cycle later, once the LB1 read has landed.
  line_ram #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(AW)) u_lb2 (
    .clk   (clk),
    .we    (s1_valid),
    .waddr (s1_addr),
    .wdata (lb1_q),
    .re    (accept),
    .raddr (addr),
    .rdata (lb2_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      armed    <= 1'b0;
      s1_valid <= 1'b0;
      s1_emit  <= 1'b0;
      s1_pix   <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= accept;
      s1_emit  <= emit;
      if (accept) begin
        s1_pix  <= pix_data;
        s1_row  <= row;
        s1_col  <= column;
        s1_addr <= addr;
        if (row == '0 && column == '0) armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 9; k++) win[k] <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      win_valid <= s1_emit;
      if (s1_valid) begin
        for (int r = 0; r < 3; r++) begin
          win[win_idx(r, 0)] <= win[win_idx(r, 1)];
          win[win_idx(r, 1)] <= win[win_idx(r, 2)];
        end
        win[WIN_P02] <= lb2_q;
        win[WIN_P12] <= lb1_q;
        win[WIN_P22] <= s1_pix;
        win_row      <= s1_row - COORD_W'(1);
        win_col      <= s1_col - COORD_W'(1);
      end
    end
  end

`ifdef WIN_FRAME_DONE_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) frame_done <= 1'b0;
    else       frame_done <= s1_emit && (s1_row == LAST_R) && (s1_col == LAST_C);
  end
`endif

  always_comb begin
    win_data = '0;
    for (int k = 0; k < 9; k++) win_data[k*DATA_W +: DATA_W] = win[k];
  end

endmodule

// File: tb/tb_window_3x3.sv
// tb/tb_window_3x3.sv - randomized/directed bench for window_3x3 against an image-array model
module tb_window_3x3;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic [7:0]    column = '0;
  logic [7:0]    row = '0;
  logic          win_valid;
  logic [9*DW-1:0] win_data;
  logic [7:0]    win_row;
  logic [7:0]    win_col;
`ifdef WIN_FRAME_DONE_EN
  logic          frame_done;
`endif

  window_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .column    (column),
    .row       (row),
    .win_valid (win_valid),
    .win_data  (win_data),
    .win_row   (win_row),
`ifdef WIN_FRAME_DONE_EN
    .frame_done(frame_done),
`endif
    .win_col   (win_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] data;
    logic [7:0]  r;
    logic [7:0]  c;
    int          due;
    int          fid;
    bit          last;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  img [H][W];
  bit          armed;
  int          tickn;
  int          total;
  int          bad;
  int          fid;
  int          win_cnt [16];
  logic [71:0] first_obs [16];
  logic [71:0] last_obs [16];
  logic [7:0]  last_r [16];
  logic [7:0]  last_c [16];

  localparam logic [71:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] LAST_WIN  = 72'h57_56_55_47_46_45_37_36_35;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit v, input int r, input int c, input logic [7:0] d);
    exp_t e;
    pix_valid = v;
    row       = 8'(r);
    column    = 8'(c);
    pix_data  = d;
    @(negedge clk);
    if (q.size() > 0 && q[0].due == tickn) begin
      e = q.pop_front();
      chk("win_valid", 72'(win_valid), 72'd1);
      chk("win_data", win_data, e.data);
      chk("win_row", 72'(win_row), 72'(e.r));
      chk("win_col", 72'(win_col), 72'(e.c));
`ifdef WIN_FRAME_DONE_EN
      chk("frame_done", 72'(frame_done), 72'(e.last));
`endif
      win_cnt[e.fid]++;
      if (win_cnt[e.fid] == 1) first_obs[e.fid] = win_data;
      last_obs[e.fid] = win_data;
      last_r[e.fid]   = win_row;
      last_c[e.fid]   = win_col;
    end else begin
      chk("win_valid_idle", 72'(win_valid), 72'd0);
`ifdef WIN_FRAME_DONE_EN
      chk("frame_done_idle", 72'(frame_done), 72'd0);
`endif
    end
    @(posedge clk);
    if (v && c >= 0 && c < W && r >= 0 && r < H) begin
      img[r][c] = d;
      if (r == 0 && c == 0) armed = 1'b1;
      if (armed && r >= 2 && c >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.data[(3*i+j)*8 +: 8] = img[r-2+i][c-2+j];
        e.r    = 8'(r - 1);
        e.c    = 8'(c - 1);
        e.due  = tickn + 2;
        e.fid  = fid;
        e.last = (r == H-1) && (c == W-1);
        q.push_back(e);
      end
    end
    tickn++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), 8'($urandom));
  endtask

  task automatic scan(input int start, input int stop, input bit rnd, input bit gaps, input bit inj);
    int r;
    int c;
    for (int idx = start; idx < stop; idx++) begin
      r = idx / W;
      c = idx % W;
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++)
          tick(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), 8'($urandom));
      if (inj && r == 3 && c == 4) begin
        tick(1'b1, 3, W, 8'hAA);
        tick(1'b1, H, 4, 8'hBB);
      end
      tick(1'b1, r, c, rnd ? 8'($urandom) : 8'(r * 16 + c));
    end
  endtask

  initial begin
    armed = 1'b0;
    tickn = 0;
    total = 0;
    bad   = 0;
    fid   = 0;
    for (int k = 0; k < 16; k++) win_cnt[k] = 0;

    #2;
    chk("rst_win_valid", 72'(win_valid), 72'd0);
    chk("rst_win_data", win_data, 72'd0);
    chk("rst_win_row", 72'(win_row), 72'd0);
    chk("rst_win_col", 72'(win_col), 72'd0);
    idle(2);
    rstn = 1'b1;
    idle(2);

    fid = 1;
    scan(0, W*H, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("f1_count", 72'(win_cnt[1]), 72'd24);
    chk("f1_first", first_obs[1], FIRST_WIN);
    chk("f1_last", last_obs[1], LAST_WIN);
    chk("f1_last_row", 72'(last_r[1]), 72'd4);
    chk("f1_last_col", 72'(last_c[1]), 72'd6);

    fid = 2;
    scan(0, W*H, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("f2_gap_count", 72'(win_cnt[2]), 72'd24);
    chk("f2_gap_first", first_obs[2], FIRST_WIN);
    chk("f2_gap_last", last_obs[2], LAST_WIN);

    fid = 3;
    scan(0, W*H, 1'b0, 1'b0, 1'b1);
    idle(3);
    chk("f3_inv_count", 72'(win_cnt[3]), 72'd24);
    chk("f3_inv_last", last_obs[3], LAST_WIN);

    fid = 4;
    scan(0, 3*W + 3, 1'b0, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_win_valid", 72'(win_valid), 72'd0);
    chk("mid_rst_win_data", win_data, 72'd0);
    chk("mid_rst_win_row", 72'(win_row), 72'd0);
    chk("mid_rst_win_col", 72'(win_col), 72'd0);
`ifdef WIN_FRAME_DONE_EN
    chk("mid_rst_frame_done", 72'(frame_done), 72'd0);
`endif
    q.delete();
    armed = 1'b0;
    idle(2);
    rstn = 1'b1;
    fid = 5;
    scan(3*W, W*H, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("resume_no_windows", 72'(win_cnt[5]), 72'd0);

    fid = 6;
    scan(0, W*H, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("restart_count", 72'(win_cnt[6]), 72'd24);
    chk("restart_first", first_obs[6], FIRST_WIN);

    fid = 7;
    scan(0, W*H, 1'b1, 1'b1, 1'b0);
    fid = 8;
    scan(0, W*H, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("rand_count", 72'(win_cnt[7]), 72'd24);
    chk("b2b_count", 72'(win_cnt[8]), 72'd24);
    chk("b2b_first", first_obs[8], FIRST_WIN);

    fid = 9;
    scan(0, W*H, 1'b1, 1'b1, 1'b1);
    idle(3);
    chk("rand_inv_count", 72'(win_cnt[9]), 72'd24);
    chk("queue_drained", 72'(q.size()), 72'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
